mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between two requesters:
  - port 0: the multicycle CPU controller/datapath (fetch, lw, sw);
  - port 1: the program loader/debug port.
- Sequences each access through a small FSM and tolerates variable memory latency via a ready handshake.
- Aborts hung accesses with a bounded-wait timeout.
- Sits between the CPU datapath memory mux (IorD path) and the memory model.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 15, cycles in ACCESS without mem_ready before timeout (range 1..255)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- c_req  in  1  CPU request; held high until c_done
- c_we  in  1  CPU write enable (1=store, 0=read)
- c_addr  in  ADDR_W  CPU address
- c_wdata  in  DATA_W  CPU write data
- c_done  out  1  one-cycle completion pulse to CPU
- l_req  in  1  loader request; held high until l_done
- l_we  in  1  loader write enable
- l_addr  in  ADDR_W  loader address
- l_wdata  in  DATA_W  loader write data
- l_done  out  1  one-cycle completion pulse to loader
- rdata  out  DATA_W  read data, valid while c_done or l_done is high
- err  out  1  timeout flag, valid while c_done or l_done is high
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion for current strobe

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; all outputs 0.
  - Last-grant pointer lp=1, so the CPU wins the first tie.
  - Wait counter 0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one requester high: grant it.
  - Both high: grant the port != lp.
  - On grant: latch port index g, we, addr and wdata into registers; lp<=g; counter<=0; go to ACCESS.
- ACCESS:
  - Outputs are driven from the latched registers: mem_read=~we_q, mem_write=we_q, mem_addr=addr_q, mem_wdata=wdata_q.
  - mem_ready=1: capture mem_rdata (0 for writes); err<=0; go to RESP.
  - Otherwise, counter==MAX_WAIT-1: err<=1; rdata<=0; go to RESP.
  - Otherwise: counter+1.
  - mem_ready and timeout in the same cycle: mem_ready wins, err=0.
- RESP:
  - Strobes are 0.
  - done for port g is 1 for exactly this cycle; rdata and err are held.
  - Next state is IDLE unconditionally.
  - A requester may start a new access from IDLE on the following cycle.
- Latency:
  - Request seen in IDLE at cycle 0, strobe at cycle 1.
  - With mem_ready at cycle 1, done pulses at cycle 2.
  - Back-to-back accesses from one port: one per 3 cycles minimum.
- Requests:
  - Inputs are sampled only at grant.
  - A req dropping mid-access is ignored; the access completes and done still pulses.
  - req held high after done is treated as a new request in IDLE.
- Other rules:
  - Strobes are never high outside ACCESS; mem_read and mem_write are never both high.
  - mem_ready outside ACCESS is ignored.
  - Counter width is 8 bits; no wrap occurs because MAX_WAIT<=255.
  - Reset mid-ACCESS: strobes drop immediately (asynchronous), no done is issued, lp returns to 1.

Decomposition:
- Shared package mem_arb_pkg:
  - state typedef {IDLE, ACCESS, RESP};
  - port index constants PORT_CPU=0, PORT_LDR=1;
  - MAX_WAIT default constant.
- One sub-module mem_wait_timer:
  - 8-bit counter with clear, enable and a terminal-count flag at MAX_WAIT-1;
  - same clk/reset_n.

Test Plan:
- Reset mid-ACCESS: drop reset_n asynchronously while mem_read=1 -> all outputs 0 the same cycle, state IDLE; after release, simultaneous req grants CPU first.
- CPU read, immediate ready: c_req=1, c_we=0, c_addr=0x10, mem_rdata=0xDEADBEEF with mem_ready at cycle 1 -> mem_read=1 and mem_addr=0x10 at cycle 1; c_done=1, rdata=0xDEADBEEF, err=0 at cycle 2.
- Loader write with 4-cycle latency: l_we=1, l_addr=0x40, l_wdata=0x1234 -> mem_write held 4 cycles, l_done exactly one cycle later, c_done stays 0.
- Simultaneous requests, both held: grants alternate CPU, loader, CPU; mem_addr follows the granted port; no done overlap.
- Timeout: CPU read, mem_ready never asserted, MAX_WAIT=15 -> mem_read high 15 cycles, then c_done=1, err=1, rdata=0; mem_ready arriving on cycle 15 instead gives err=0.
- Request withdrawal: c_req deasserted one cycle after grant -> access still completes, c_done pulses once, arbiter returns to IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter slice.
// Provides the arbiter state encoding, the requester port indices and the
// default bounded-wait limit used by the timeout counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam int unsigned MAX_WAIT_DEFAULT = 15;
    localparam int unsigned WAIT_CNT_W       = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus between the arbiter and the unified memory model.
// Ports (signals):
//   mem_read / mem_write : access strobes, high only while an access is active
//   mem_addr / mem_wdata : address and write data for the current strobe
//   mem_rdata            : read data, valid with mem_ready
//   mem_ready            : memory completion for the current strobe
// Modports: master = arbiter side, slave = memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter_timer.sv
// Bounded-wait counter for a pending memory access.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   clr          : restart the count at zero (takes priority over en)
//   en           : advance the count by one
//   tc           : terminal count, high while the count equals MAX_WAIT-1
module mem_wait_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [WAIT_CNT_W-1:0] TC_VAL = WAIT_CNT_W'(MAX_WAIT - 1);

    logic [WAIT_CNT_W-1:0] count;

    // MAX_WAIT is at most 255, so the owner stops enabling at TC_VAL and the
    // counter never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WAIT_CNT_W'(1);
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-ported unified instruction/data memory.
// Port 0 is the multicycle CPU, port 1 the program loader/debug port.
// Each access runs IDLE -> ACCESS -> RESP; ACCESS waits for mem_ready or
// gives up after MAX_WAIT cycles and reports err.
// Ports:
//   clk, reset_n                      : clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata, c_done : CPU request and one-cycle completion
//   l_req/l_we/l_addr/l_wdata, l_done : loader request and one-cycle completion
//   rdata, err                        : read data / timeout flag, valid with done
//   mem                               : memory bus (master side)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_done,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    mem_port_arbiter_if.master mem
);

    arb_state_t        state, state_d;
    logic              g_q, lp_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              grant;
    logic              gsel;
    logic              t_clr, t_en, t_tc;

    logic              rd_o, wr_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] wdata_o;
    logic              cdone_o, ldone_o;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (t_clr),
        .en      (t_en),
        .tc      (t_tc)
    );

    // Next state, grant selection and all outputs. The bus outputs are
    // purely state-decoded, so the asynchronous reset clears them at once.
    always_comb begin
        state_d = state;
        grant   = 1'b0;
        gsel    = PORT_CPU;
        t_clr   = 1'b0;
        t_en    = 1'b0;
        rd_o    = 1'b0;
        wr_o    = 1'b0;
        addr_o  = '0;
        wdata_o = '0;
        cdone_o = 1'b0;
        ldone_o = 1'b0;

        unique case (state)
            IDLE: begin
                if (c_req && l_req) begin
                    // Tie goes to the port that did not win last time.
                    gsel  = (lp_q == PORT_CPU) ? PORT_LDR : PORT_CPU;
                    grant = 1'b1;
                end else if (c_req) begin
                    gsel  = PORT_CPU;
                    grant = 1'b1;
                end else if (l_req) begin
                    gsel  = PORT_LDR;
                    grant = 1'b1;
                end
                if (grant) begin
                    state_d = ACCESS;
                    t_clr   = 1'b1;
                end
            end
            ACCESS: begin
                rd_o    = ~we_q;
                wr_o    = we_q;
                addr_o  = addr_q;
                wdata_o = wdata_q;
                if (mem.mem_ready || t_tc) begin
                    state_d = RESP;
                end else begin
                    t_en = 1'b1;
                end
            end
            RESP: begin
                cdone_o = (g_q == PORT_CPU);
                ldone_o = (g_q == PORT_LDR);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g_q     <= PORT_CPU;
            lp_q    <= PORT_LDR;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (grant) begin
                g_q     <= gsel;
                lp_q    <= gsel;
                we_q    <= (gsel == PORT_LDR) ? l_we    : c_we;
                addr_q  <= (gsel == PORT_LDR) ? l_addr  : c_addr;
                wdata_q <= (gsel == PORT_LDR) ? l_wdata : c_wdata;
            end
            if (state == ACCESS) begin
                // mem_ready beats a coincident timeout.
                if (mem.mem_ready) begin
                    rdata_q <= we_q ? '0 : mem.mem_rdata;
                    err_q   <= 1'b0;
                end else if (t_tc) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign mem.mem_read  = rd_o;
    assign mem.mem_write = wr_o;
    assign mem.mem_addr  = addr_o;
    assign mem.mem_wdata = wdata_o;
    assign c_done        = cdone_o;
    assign l_done        = ldone_o;
    assign rdata         = rdata_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a per-cycle vector table for the
// basic transactions plus hand-written sequences for timeout, request
// withdrawal and asynchronous reset during an access.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        c_req, c_we, l_req, l_we;
    logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
    logic        c_done, l_done, err;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (15)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .c_req   (c_req),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_done  (c_done),
        .l_req   (l_req),
        .l_we    (l_we),
        .l_addr  (l_addr),
        .l_wdata (l_wdata),
        .l_done  (l_done),
        .rdata   (rdata),
        .err     (err),
        .mem     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] c_req, c_we, c_addr, c_wdata;
        logic [31:0] l_req, l_we, l_addr, l_wdata;
        logic [31:0] rdy, mrd;
        logic [31:0] e_rd, e_wr, e_addr, e_wdata, e_cd, e_ld;
        logic [31:0] chk, e_rdata, e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic [31:0] cr, cw, ca, cwd,
        input logic [31:0] lr, lw, la, lwd,
        input logic [31:0] rdy, mrd,
        input logic [31:0] erd, ewr, ea, ewd, ecd, eld,
        input logic [31:0] chk, erdata, eerr
    );
        vec_t r;
        r.c_req = cr;  r.c_we = cw;  r.c_addr = ca;  r.c_wdata = cwd;
        r.l_req = lr;  r.l_we = lw;  r.l_addr = la;  r.l_wdata = lwd;
        r.rdy = rdy;   r.mrd = mrd;
        r.e_rd = erd;  r.e_wr = ewr; r.e_addr = ea;  r.e_wdata = ewd;
        r.e_cd = ecd;  r.e_ld = eld;
        r.chk = chk;   r.e_rdata = erdata; r.e_err = eerr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_chk(input string tag,
                           input logic [31:0] erd, ewr, ea, ewd, ecd, eld);
        chk({tag, ".mem_read"},  {31'b0, bus.mem_read},  erd);
        chk({tag, ".mem_write"}, {31'b0, bus.mem_write}, ewr);
        chk({tag, ".mem_addr"},  bus.mem_addr,           ea);
        chk({tag, ".mem_wdata"}, bus.mem_wdata,          ewd);
        chk({tag, ".c_done"},    {31'b0, c_done},        ecd);
        chk({tag, ".l_done"},    {31'b0, l_done},        eld);
    endtask

    task automatic resp_chk(input string tag, input logic [31:0] erdata, eerr);
        chk({tag, ".rdata"}, rdata,          erdata);
        chk({tag, ".err"},   {31'b0, err},   eerr);
    endtask

    task automatic drive(input vec_t x);
        c_req = x.c_req[0]; c_we = x.c_we[0]; c_addr = x.c_addr; c_wdata = x.c_wdata;
        l_req = x.l_req[0]; l_we = x.l_we[0]; l_addr = x.l_addr; l_wdata = x.l_wdata;
        bus.mem_ready = x.rdy[0];
        bus.mem_rdata = x.mrd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        #2 reset_n = 1'b0;
        #1;
        bus_chk("reset", 0, 0, 0, 0, 0, 0);
        resp_chk("reset", 0, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // CPU read, immediate ready; stray mem_ready in IDLE ignored
        vecs.push_back(v(1,0,'h10,0, 0,0,0,0, 0,0,             0,0,0,0, 0,0, 0,0,0));
        vecs.push_back(v(1,0,'h10,0, 0,0,0,0, 1,'hDEADBEEF,    1,0,'h10,0, 0,0, 0,0,0));
        vecs.push_back(v(1,0,'h10,0, 0,0,0,0, 0,0,             0,0,0,0, 1,0, 1,'hDEADBEEF,0));
        vecs.push_back(v(0,0,0,0,    0,0,0,0, 1,'hFFFFFFFF,    0,0,0,0, 0,0, 0,0,0));
        vecs.push_back(v(0,0,0,0,    0,0,0,0, 0,0,             0,0,0,0, 0,0, 0,0,0));
        // Loader write, 4-cycle memory latency
        vecs.push_back(v(0,0,0,0, 1,1,'h40,'h1234, 0,0,          0,0,0,0, 0,0, 0,0,0));
        vecs.push_back(v(0,0,0,0, 1,1,'h40,'h1234, 0,0,          0,1,'h40,'h1234, 0,0, 0,0,0));
        vecs.push_back(v(0,0,0,0, 1,1,'h40,'h1234, 0,0,          0,1,'h40,'h1234, 0,0, 0,0,0));
        vecs.push_back(v(0,0,0,0, 1,1,'h40,'h1234, 0,0,          0,1,'h40,'h1234, 0,0, 0,0,0));
        vecs.push_back(v(0,0,0,0, 1,1,'h40,'h1234, 1,'h55555555, 0,1,'h40,'h1234, 0,0, 0,0,0));
        vecs.push_back(v(0,0,0,0, 1,1,'h40,'h1234, 0,0,          0,0,0,0, 0,1, 1,0,0));
        vecs.push_back(v(0,0,0,0, 0,0,0,0,         0,0,          0,0,0,0, 0,0, 0,0,0));
        // Both requesting: CPU, loader, CPU
        vecs.push_back(v(1,0,'h20,0, 1,0,'h80,0, 0,0,           0,0,0,0, 0,0, 0,0,0));
        vecs.push_back(v(1,0,'h20,0, 1,0,'h80,0, 1,'h11111111,  1,0,'h20,0, 0,0, 0,0,0));
        vecs.push_back(v(1,0,'h20,0, 1,0,'h80,0, 0,0,           0,0,0,0, 1,0, 1,'h11111111,0));
        vecs.push_back(v(1,0,'h20,0, 1,0,'h80,0, 0,0,           0,0,0,0, 0,0, 0,0,0));
        vecs.push_back(v(1,0,'h20,0, 1,0,'h80,0, 1,'h22222222,  1,0,'h80,0, 0,0, 0,0,0));
        vecs.push_back(v(1,0,'h20,0, 1,0,'h80,0, 0,0,           0,0,0,0, 0,1, 1,'h22222222,0));
        vecs.push_back(v(1,0,'h20,0, 1,0,'h80,0, 0,0,           0,0,0,0, 0,0, 0,0,0));
        vecs.push_back(v(1,0,'h20,0, 1,0,'h80,0, 1,'h33333333,  1,0,'h20,0, 0,0, 0,0,0));
        vecs.push_back(v(0,0,0,0,    0,0,0,0,    0,0,           0,0,0,0, 1,0, 1,'h33333333,0));
        vecs.push_back(v(0,0,0,0,    0,0,0,0,    0,0,           0,0,0,0, 0,0, 0,0,0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            bus_chk($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_addr,
                    vecs[i].e_wdata, vecs[i].e_cd, vecs[i].e_ld);
            if (vecs[i].chk[0])
                resp_chk($sformatf("vec%0d", i), vecs[i].e_rdata, vecs[i].e_err);
        end

        // Timeout: no mem_ready for 15 ACCESS cycles
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b0; c_addr = 'h100; c_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 'hBAD0BAD0;
        #1 bus_chk("to.idle", 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            #1 bus_chk($sformatf("to.acc%0d", k), 1, 0, 'h100, 0, 0, 0);
        end
        @(negedge clk);
        c_req = 1'b0;
        #1 bus_chk("to.resp", 0, 0, 0, 0, 1, 0);
        resp_chk("to.resp", 0, 1);
        @(negedge clk);
        #1 bus_chk("to.after", 0, 0, 0, 0, 0, 0);

        // mem_ready on the last allowed cycle wins over the timeout
        @(negedge clk);
        c_req = 1'b1; c_addr = 'h104;
        #1 bus_chk("tr.idle", 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 14) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 'hCAFEF00D;
            end
            #1 bus_chk($sformatf("tr.acc%0d", k), 1, 0, 'h104, 0, 0, 0);
        end
        @(negedge clk);
        c_req = 1'b0; bus.mem_ready = 1'b0;
        #1 bus_chk("tr.resp", 0, 0, 0, 0, 1, 0);
        resp_chk("tr.resp", 'hCAFEF00D, 0);

        // Request withdrawn one cycle after grant
        @(negedge clk);
        c_req = 1'b1; c_addr = 'h55;
        #1 bus_chk("wd.idle", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        c_req = 1'b0;
        #1 bus_chk("wd.acc0", 1, 0, 'h55, 0, 0, 0);
        @(negedge clk);
        bus.mem_ready = 1'b1; bus.mem_rdata = 'h0F0F0F0F;
        #1 bus_chk("wd.acc1", 1, 0, 'h55, 0, 0, 0);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1 bus_chk("wd.resp", 0, 0, 0, 0, 1, 0);
        resp_chk("wd.resp", 'h0F0F0F0F, 0);
        @(negedge clk);
        #1 bus_chk("wd.idle1", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1 bus_chk("wd.idle2", 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-ACCESS, then a tie must go to the CPU
        @(negedge clk);
        c_req = 1'b1; c_addr = 'h60;
        @(negedge clk);
        #1 bus_chk("rs.acc", 1, 0, 'h60, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1 bus_chk("rs.async", 0, 0, 0, 0, 0, 0);
        resp_chk("rs.async", 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        l_req = 1'b1; l_we = 1'b0; l_addr = 'h70;
        #1 bus_chk("rs.idle", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        bus.mem_ready = 1'b1; bus.mem_rdata = 'h600D600D;
        #1 bus_chk("rs.tie", 1, 0, 'h60, 0, 0, 0);
        @(negedge clk);
        bus.mem_ready = 1'b0; c_req = 1'b0; l_req = 1'b0;
        #1 bus_chk("rs.resp", 0, 0, 0, 0, 1, 0);
        resp_chk("rs.resp", 'h600D600D, 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
